multi_coordinator: RTL



---
 rtl/multi_coordinator_pkg.sv | 19 +
 rtl/multi_coordinator_rr_pick.sv | 29 ++
 rtl/multi_coordinator.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/multi_coordinator_pkg.sv
// Shared encodings for the multi-channel SDRAM coordinator: FSM states,
// transfer classes and class-priority modes.
package multi_coordinator_pkg;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    // Transfer class of the most recent grant.
    localparam logic CLS_WRITE = 1'b0;
    localparam logic CLS_READ  = 1'b1;

    // Class priority when both classes have pending requests.
    localparam int PRIO_WRITE_FIRST = 0;
    localparam int PRIO_ALTERNATE   = 1;

endpackage

// File: rtl/multi_coordinator_rr_pick.sv
// Round-robin picker: finds the first set request bit at or above ptr,
// wrapping modulo N. Purely combinational.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] idx
);

    int c;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        c   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % N;
            if (req[c]) begin
                any = 1'b1;
                idx = PW'(c);
            end
        end
    end

endmodule

// File: rtl/multi_coordinator.sv
// Multi-channel SDRAM coordinator: watches ingress/egress FIFO levels,
// issues one-cycle write/read burst strobes tagged with a channel index,
// round-robins within each class and guards each handshake with a watchdog.
//
// Handshake: a strobe is issued only while sd_ready=1 in S_WAIT; the
// controller acknowledges by dropping sd_ready, which returns us to S_WAIT.
// If sd_ready stays high for TIMEOUT cycles after the strobe, timeout_err
// pulses and we return to S_WAIT anyway.
module multi_coordinator
    import multi_coordinator_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int USEDW_W   = 8,
    parameter int WR_THRESH = 120,
    parameter int RD_THRESH = 60,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic                        sdram_clk,
    input  logic                        reset,
    input  logic [NUM_CH*USEDW_W-1:0]   inusedw,
    input  logic [NUM_CH*USEDW_W-1:0]   outusedw,
    input  logic                        sd_ready,
    output logic                        wr_strobe,
    output logic                        rd_strobe,
    output logic [$clog2(NUM_CH)-1:0]   ch_sel,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int CH_W = $clog2(NUM_CH);

    state_t          state_q, state_d;
    logic [CH_W-1:0] ch_sel_d, wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
    logic [7:0]      timer, timer_d;
    logic            last_class, last_class_d;
    logic            busy_d, wr_strobe_d, rd_strobe_d, timeout_d;

    logic [NUM_CH-1:0] wr_req, rd_req;
    logic              wr_any, rd_any;
    logic [CH_W-1:0]   wr_idx, rd_idx;
    logic              pick_write, pick_read;

    // Per-channel request flags from FIFO levels (unsigned compares).
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wr_req[i] = inusedw[i*USEDW_W +: USEDW_W]  >= USEDW_W'(WR_THRESH);
            rd_req[i] = outusedw[i*USEDW_W +: USEDW_W] <= USEDW_W'(RD_THRESH);
        end
    end

    rr_pick #(.N(NUM_CH), .PW(CH_W)) u_wr_pick (
        .req (wr_req),
        .ptr (wr_ptr),
        .any (wr_any),
        .idx (wr_idx)
    );

    rr_pick #(.N(NUM_CH), .PW(CH_W)) u_rd_pick (
        .req (rd_req),
        .ptr (rd_ptr),
        .any (rd_any),
        .idx (rd_idx)
    );

    // Class choice: in alternate mode a tie goes to the class not served last.
    always_comb begin
        pick_write = wr_any && ((PRIO_MODE == PRIO_WRITE_FIRST) || !rd_any ||
                                (last_class == CLS_READ));
        pick_read  = rd_any && !pick_write;
    end

    // Next-state and next-output logic; strobes and timeout default low.
    always_comb begin
        state_d      = state_q;
        ch_sel_d     = ch_sel;
        wr_ptr_d     = wr_ptr;
        rd_ptr_d     = rd_ptr;
        timer_d      = timer;
        last_class_d = last_class;
        busy_d       = busy;
        wr_strobe_d  = 1'b0;
        rd_strobe_d  = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (sd_ready) begin
                    if (pick_write) begin
                        wr_strobe_d  = 1'b1;
                        ch_sel_d     = wr_idx;
                        wr_ptr_d     = (wr_idx == CH_W'(NUM_CH - 1)) ? '0 : wr_idx + 1'b1;
                        last_class_d = CLS_WRITE;
                        timer_d      = '0;
                        busy_d       = 1'b1;
                        state_d      = S_WR;
                    end else if (pick_read) begin
                        rd_strobe_d  = 1'b1;
                        ch_sel_d     = rd_idx;
                        rd_ptr_d     = (rd_idx == CH_W'(NUM_CH - 1)) ? '0 : rd_idx + 1'b1;
                        last_class_d = CLS_READ;
                        timer_d      = '0;
                        busy_d       = 1'b1;
                        state_d      = S_RD;
                    end
                end
            end
            S_WR, S_RD: begin
                timer_d = timer + 8'd1;
                if (!sd_ready) begin
                    busy_d  = 1'b0;
                    state_d = S_WAIT;
                end else if (timer == 8'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_WAIT;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_WAIT;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sdram_clk) begin
        if (reset) begin
            state_q     <= S_WAIT;
            ch_sel      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            timer       <= '0;
            last_class  <= CLS_READ;
            busy        <= 1'b0;
            wr_strobe   <= 1'b0;
            rd_strobe   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_sel      <= ch_sel_d;
            wr_ptr      <= wr_ptr_d;
            rd_ptr      <= rd_ptr_d;
            timer       <= timer_d;
            last_class  <= last_class_d;
            busy        <= busy_d;
            wr_strobe   <= wr_strobe_d;
            rd_strobe   <= rd_strobe_d;
            timeout_err <= timeout_d;
        end
    end

endmodule
